npu_loader: RTL
===============

# npu_loader

Feature-map/weight loader that drives the NPU memory write port (`write_w`, `write_h`, `data_in`, `en_in`). It accepts a byte stream over a valid/ready handshake, packs the bytes into the 9 memory lanes, and issues one write per column. It walks columns 0..cols-1 inside rows 0..rows-1. It is the transmitting end of the NPU memory-write interface and sits between the host/DMA byte stream and the `npu` top.

## Interface
- `width`, 80, memory columns per row
- `height`, 8, memory rows
- `width_b`, 7, column address width
- `height_b`, 3, row address width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a load; ignored unless idle
- `cfg_lanes`  in  9  lane enable mask, latched at start
- `cfg_cols`  in  width_b+1  columns to write, latched at start; clamped to `width`
- `cfg_rows`  in  height_b+1  rows to write, latched at start; clamped to `height`
- `s_data`  in  8  stream byte
- `s_valid`  in  1  stream byte valid
- `s_ready`  out  1  loader accepts byte this cycle
- `write_w`  out  width_b  column address
- `write_h`  out  height_b  row address
- `data_in`  out  72  packed lanes; lane k is bits 8k+7:8k
- `en_in`  out  9  per-lane write enable, one-cycle pulse
- `busy`  out  1  high from the cycle after an accepted start until done
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, COLLECT, WRITE, DONE.
- **IDLE**
  - `start` latches the cfg inputs and clears the row, column and lane counters.
  - If the latched mask is 0, or the clamped cols or rows are 0, go to DONE. Otherwise go to COLLECT.
- **COLLECT**
  - `s_ready` = 1.
  - Each handshake (`s_valid && s_ready`) stores `s_data` into the lowest enabled lane not yet filled this column.
  - Bytes go in ascending lane order. Disabled lanes hold 0.
  - After the last enabled lane is filled, go to WRITE.
- **WRITE**
  - `s_ready` = 0.
  - Present `en_in` = latched mask with the current `write_w`/`write_h`/`data_in` for exactly one cycle.
  - Then increment the column. On column = cols-1, wrap the column to 0 and increment the row.
  - On the last column of the last row, go to DONE. Otherwise go to COLLECT with the lane buffer cleared.
- **DONE**
  - `done` = 1 for one cycle, then IDLE.
- `start` is ignored in every state except IDLE.
- Mid-load stalls (`s_valid` low) are unbounded. No timeout.
- Clamping: `cfg_cols` > `width` is treated as `width`; `cfg_rows` > `height` is treated as `height`.

## Timing
- All outputs are registered except `s_ready`, which is decoded from the state register only (no combinational path from `s_valid`).
- Reset values:
  - state = IDLE.
  - `s_ready`, `busy`, `done`, `en_in`, `write_w`, `write_h`, `data_in` = 0.
- `en_in` is 0 in every cycle except WRITE cycles.
- `data_in`, `write_w` and `write_h` are stable during the `en_in` cycle. They hold their last values otherwise.
- Per column: N accept cycles (N = popcount of the mask) plus 1 write cycle. Back-to-back `s_valid` gives exactly N+1 cycles per column.
- Latency:
  - `start` to first `s_ready`: 1 cycle.
  - Last byte accepted to `en_in`: 1 cycle.
  - Final `en_in` to `done`: 1 cycle.
  - Degenerate config: `start` to `done` is 1 cycle, with no `en_in` pulse and no bytes consumed.
- `busy` is high in COLLECT and WRITE. It is low in IDLE and DONE.
- Reset asserted mid-load: immediate return to IDLE, partial lane data discarded, no further `en_in`, `done` not pulsed.

## Structure
- Shared package: FSM state encoding, lane count (9), byte width (8), and a popcount function for the 9-bit mask.
- One sub-module is natural: `lane_pack`. It holds the lane pointer that finds the next enabled lane, the 72-bit buffer write, and the last-lane flag.
- The FSM and the row/column counters stay in `npu_loader`.

## Test plan
- Mask 9'h1FF, cols 2, rows 1, bytes 0x01..0x12 streamed continuously:
  - two `en_in` = 1FF pulses, at columns 0 and 1, row 0;
  - first `data_in` = 0x090807060504030201;
  - `done` arrives 21 cycles after `start`.
- Mask 9'h005, cols 1, rows 1, bytes 0xAA, 0xBB:
  - `data_in` lane0 = AA, lane2 = BB, all other lanes 0;
  - `en_in` = 005.
- Mask 9'h1FF, cols 200, rows 9, full stream:
  - clamped to 80×8 = 640 writes;
  - the last write has `write_w` = 79, `write_h` = 7, then `done`.
- Random `s_valid` gaps, and `start` pulsed while busy:
  - `data_in` matches a reference packer;
  - the extra `start` has no effect;
  - no `en_in` is issued without a full column.
- Mask 0 → `done` 1 cycle after `start`, with no `s_ready` and no `en_in`.
- Reset after 4 bytes of a column:
  - all outputs go to 0 immediately;
  - a new load afterwards starts at w = 0, h = 0, lane 0.

Source files
------------

// File: rtl/npu_loader_pkg.sv
// npu_loader_pkg: shared geometry, FSM encoding and lane popcount for the NPU loader
package npu_loader_pkg;
  localparam int LANES    = 9;
  localparam int BYTE_W   = 8;
  localparam int WIDTH    = 80;
  localparam int HEIGHT   = 8;
  localparam int WIDTH_B  = 7;
  localparam int HEIGHT_B = 3;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
  function automatic logic [3:0] popcount9(input logic [LANES-1:0] m);
    popcount9 = '0;
    for (int i = 0; i < LANES; i++) popcount9 = popcount9 + {3'b0, m[i]};
  endfunction
endpackage

// File: rtl/npu_loader_lane_pack.sv
// npu_loader_lane_pack: steers stream bytes into the lowest enabled, unfilled lane
module npu_loader_lane_pack
  import npu_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic [LANES-1:0]        mask_i,
  input  logic [BYTE_W-1:0]       data_i,
  output logic [LANES*BYTE_W-1:0] pack_d_o,
  output logic                    last_o
);
  logic [LANES-1:0] fill_q, rem, ptr;
  logic [LANES*BYTE_W-1:0] pack_q;
  assign rem = mask_i & ~fill_q;
  // one-hot lane pointer: lowest set bit of the remaining lanes
  assign ptr = rem & (~rem + LANES'(1));
  assign last_o = popcount9(rem) == 4'd1;
  always_comb begin
    pack_d_o = pack_q;
    for (int k = 0; k < LANES; k++)
      if (push_i && ptr[k]) pack_d_o[k*BYTE_W +: BYTE_W] = data_i;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fill_q <= '0;
      pack_q <= '0;
    end else if (clr_i) begin
      fill_q <= '0;
      pack_q <= '0;
    end else if (push_i) begin
      fill_q <= fill_q | ptr;
      pack_q <= pack_d_o;
    end
endmodule

// File: rtl/npu_loader.sv
// npu_loader: packs a byte stream into 9-lane column writes for the NPU memory port
module npu_loader
  import npu_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LANES-1:0]        cfg_lanes,
  input  logic [WIDTH_B:0]        cfg_cols,
  input  logic [HEIGHT_B:0]       cfg_rows,
  input  logic [BYTE_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [WIDTH_B-1:0]      write_w,
  output logic [HEIGHT_B-1:0]     write_h,
  output logic [LANES*BYTE_W-1:0] data_in,
  output logic [LANES-1:0]        en_in,
  output logic                    busy,
  output logic                    done
);
  localparam logic [WIDTH_B:0]  COLS_MAX = WIDTH;
  localparam logic [HEIGHT_B:0] ROWS_MAX = HEIGHT;
  state_t state_q, state_d;
  logic [LANES-1:0] mask_q;
  logic [WIDTH_B:0] cols_q, cols_c;
  logic [HEIGHT_B:0] rows_q, rows_c;
  logic [WIDTH_B-1:0] col_q, w_q;
  logic [HEIGHT_B-1:0] row_q, h_q;
  logic [LANES*BYTE_W-1:0] data_q, pack_d;
  logic go, push, last, last_col, last_row;
  assign cols_c   = cfg_cols > COLS_MAX ? COLS_MAX : cfg_cols;
  assign rows_c   = cfg_rows > ROWS_MAX ? ROWS_MAX : cfg_rows;
  assign go       = start && state_q == S_IDLE;
  assign push     = s_valid && s_ready;
  assign last_col = {1'b0, col_q} == cols_q - (WIDTH_B+1)'(1);
  assign last_row = {1'b0, row_q} == rows_q - (HEIGHT_B+1)'(1);
  npu_loader_lane_pack u_pack (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (go || state_q == S_WRITE),
    .push_i   (push),
    .mask_i   (mask_q),
    .data_i   (s_data),
    .pack_d_o (pack_d),
    .last_o   (last)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cols_q  <= '0;
      rows_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        mask_q <= cfg_lanes;
        cols_q <= cols_c;
        rows_q <= rows_c;
        col_q  <= '0;
        row_q  <= '0;
      end
      // the write port registers only move on a completed column, so they hold between writes
      if (push && last) begin
        w_q    <= col_q;
        h_q    <= row_q;
        data_q <= pack_d;
      end
      if (state_q == S_WRITE) begin
        col_q <= last_col ? '0 : col_q + WIDTH_B'(1);
        if (last_col) row_q <= row_q + HEIGHT_B'(1);
      end
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (cfg_lanes == '0 || cols_c == '0 || rows_c == '0) ? S_DONE : S_COLLECT;
      S_COLLECT: if (push && last) state_d = S_WRITE;
      S_WRITE:   state_d = (last_col && last_row) ? S_DONE : S_COLLECT;
      default:   state_d = S_IDLE;
    endcase
  end
  always_comb begin
    s_ready = state_q == S_COLLECT;
    busy    = state_q == S_COLLECT || state_q == S_WRITE;
    done    = state_q == S_DONE;
    en_in   = state_q == S_WRITE ? mask_q : '0;
  end
  assign write_w = w_q;
  assign write_h = h_q;
  assign data_in = data_q;
endmodule
